// File: rtl/lfsr_crypt_seq.sv
// rtl/lfsr_crypt_seq.sv - FSM sequencer for the LFSR encryption datapath
//
// Purpose: on a go pulse, reads pre_len/taps/start from dat_mem, seeds the
// LFSR, then walks the preamble and message phases, writing the encrypted
// stream from DST_BASE upwards. It then raises done.
// Ports:
//   i_clk, i_init (sync active-high reset), i_go (start request)
//   i_data_out    dat_mem asynchronous read data
//   o_raddr/o_waddr/o_write_en           dat_mem addressing
//   o_lfsr_en/o_load_lfsr                lfsr6 control
//   o_prelen_en/o_taps_en/o_start_en     temp register loads
//   o_pre_sel     data_in mux select (1 = preamble pattern)
//   o_busy/o_done status
module lfsr_crypt_seq #(
  parameter int MSG_LEN  = 50,
  parameter int CFG_BASE = 61,
  parameter int DST_BASE = 64,
  parameter int PRE_MIN  = 7,
  parameter int PRE_MAX  = 12
) (
  input  logic       i_clk,
  input  logic       i_init,
  input  logic       i_go,
  input  logic [7:0] i_data_out,
  output logic [7:0] o_raddr,
  output logic [7:0] o_waddr,
  output logic       o_write_en,
  output logic       o_lfsr_en,
  output logic       o_prelen_en,
  output logic       o_taps_en,
  output logic       o_start_en,
  output logic       o_load_lfsr,
  output logic       o_pre_sel,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] CFG8     = 8'(CFG_BASE);
  localparam logic [7:0] DST8     = 8'(DST_BASE);
  localparam logic [7:0] PMIN8    = 8'(PRE_MIN);
  localparam logic [7:0] PMAX8    = 8'(PRE_MAX);
  localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_PRE, S_CFG_TAPS, S_CFG_START, S_LOAD, S_PRE, S_MSG, S_FIN
  } state_t;

  state_t     r_state;
  logic [7:0] r_p;    // clamped preamble length
  logic [7:0] r_idx;  // position within the current phase
  logic [7:0] w_pre_clamp;

  // Only the clamped value is ever kept, so raw pre_len never reaches addressing.
  assign w_pre_clamp = (i_data_out < PMIN8) ? PMIN8 :
                       (i_data_out > PMAX8) ? PMAX8 : i_data_out;

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_go) r_state <= S_CFG_PRE;
        S_CFG_PRE: begin
          r_p     <= w_pre_clamp;
          r_state <= S_CFG_TAPS;
        end
        S_CFG_TAPS:  r_state <= S_CFG_START;
        S_CFG_START: r_state <= S_LOAD;
        S_LOAD: begin
          r_idx   <= '0;
          r_state <= S_PRE;
        end
        S_PRE: begin
          if (r_idx == r_p - 8'd1) begin
            r_idx   <= '0;
            r_state <= S_MSG;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        S_MSG: begin
          if (r_idx == MSG_LAST) begin
            r_idx   <= '0;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        S_FIN: if (i_go) r_state <= S_CFG_PRE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_raddr     = '0;
    o_waddr     = DST8;
    o_write_en  = 1'b0;
    o_lfsr_en   = 1'b0;
    o_prelen_en = 1'b0;
    o_taps_en   = 1'b0;
    o_start_en  = 1'b0;
    o_load_lfsr = 1'b0;
    o_pre_sel   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_CFG_PRE: begin
        o_raddr     = CFG8;
        o_prelen_en = 1'b1;
        o_busy      = 1'b1;
      end
      S_CFG_TAPS: begin
        o_raddr   = CFG8 + 8'd1;
        o_taps_en = 1'b1;
        o_busy    = 1'b1;
      end
      S_CFG_START: begin
        o_raddr    = CFG8 + 8'd2;
        o_start_en = 1'b1;
        o_busy     = 1'b1;
      end
      S_LOAD: begin
        o_load_lfsr = 1'b1;
        o_busy      = 1'b1;
      end
      S_PRE: begin
        o_write_en = 1'b1;
        o_lfsr_en  = 1'b1;
        o_pre_sel  = 1'b1;
        o_waddr    = DST8 + r_idx;
        o_busy     = 1'b1;
      end
      S_MSG: begin
        o_write_en = 1'b1;
        o_lfsr_en  = 1'b1;
        o_raddr    = r_idx;
        o_waddr    = DST8 + r_p + r_idx;
        o_busy     = 1'b1;
      end
      S_FIN: o_done = 1'b1;
      default: ;
    endcase
    // A reset cycle must never disturb memory or the LFSR, even mid-run.
    if (i_init) begin
      o_write_en  = 1'b0;
      o_lfsr_en   = 1'b0;
      o_prelen_en = 1'b0;
      o_taps_en   = 1'b0;
      o_start_en  = 1'b0;
      o_load_lfsr = 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_crypt_seq.sv
// tb/tb_lfsr_crypt_seq.sv - self-checking bench for lfsr_crypt_seq
module tb_lfsr_crypt_seq;

  localparam int L = 50;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       go = 1'b0;
  logic [7:0] data_out;
  logic [7:0] raddr, waddr;
  logic       write_en, lfsr_en, prelen_en, taps_en, start_en, load_lfsr;
  logic       pre_sel, busy, done;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         g_fin = 1'b0;

  assign data_out = mem[raddr];

  always #5 clk = ~clk;

  lfsr_crypt_seq dut (
    .i_clk(clk), .i_init(init), .i_go(go), .i_data_out(data_out),
    .o_raddr(raddr), .o_waddr(waddr), .o_write_en(write_en),
    .o_lfsr_en(lfsr_en), .o_prelen_en(prelen_en), .o_taps_en(taps_en),
    .o_start_en(start_en), .o_load_lfsr(load_lfsr), .o_pre_sel(pre_sel),
    .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ctrl_now();
    return {24'd0, write_en, lfsr_en, prelen_en, taps_en, start_en, load_lfsr, busy, done};
  endfunction

  // One go-initiated run. Cycle 0 is the cycle in which go is presented.
  // Expected behaviour comes from the timeline: 4 setup cycles, P preamble
  // writes, L message writes, then done.
  task automatic run(input int pre_len, input bit hold_go, input int abort_at, input int extra);
    int p, d, last, nwr, ce;
    bit from_fin;
    bit we, ps;
    int exp_ctrl;
    p = (pre_len < 7) ? 7 : (pre_len > 12) ? 12 : pre_len;
    d = 5 + p + L;
    last = (abort_at >= 0) ? abort_at + 3 : d + extra;
    from_fin = g_fin;
    mem[61] = 8'(pre_len);
    mem[62] = 8'($urandom);
    mem[63] = 8'($urandom);
    for (int i = 0; i < L; i++) mem[i] = 8'($urandom);
    nwr = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      go   = (c == 0) || hold_go;
      init = (c == abort_at);
      #1;
      if (write_en) nwr++;
      if (abort_at >= 0 && c == abort_at) begin
        chk("abort_we", write_en, 0);
        chk("abort_lfsr_en", lfsr_en, 0);
        chk("abort_done", done, 0);
        continue;
      end
      if (abort_at >= 0 && c > abort_at) begin
        chk("after_abort_ctrl", ctrl_now(), 0);
        continue;
      end
      ce = (hold_go && c > d) ? c - d : c;
      we = (ce >= 5) && (ce < d);
      exp_ctrl = {24'd0, we, we, ce == 1, ce == 2, ce == 3, ce == 4,
                  (ce >= 1) && (ce < d), (ce >= d) || (ce == 0 && from_fin)};
      chk($sformatf("ctrl_c%0d", c), ctrl_now(), exp_ctrl);
      if (we) begin
        ps = (ce < 5 + p);
        chk($sformatf("pre_sel_c%0d", c), pre_sel, ps);
        chk($sformatf("waddr_c%0d", c), waddr, 64 + ce - 5);
        if (!ps) chk($sformatf("raddr_msg_c%0d", c), raddr, ce - 5 - p);
      end
      if (ce >= 1 && ce <= 3) chk($sformatf("raddr_cfg_c%0d", c), raddr, 60 + ce);
      if (ce == 0 && !from_fin) begin
        chk("idle_raddr", raddr, 0);
        chk("idle_waddr", waddr, 64);
      end
    end
    if (abort_at < 0 && !hold_go) chk("total_writes", nwr, p + L);
    @(negedge clk);
    go = 1'b0;
    init = 1'b0;
    g_fin = (abort_at < 0);
  endtask

  task automatic pulse_init();
    @(negedge clk);
    go = 1'b0;
    init = 1'b1;
    #1;
    chk("init_enables", ctrl_now() & 32'hFC, 0);
    @(negedge clk);
    init = 1'b0;
    #1;
    chk("post_init_ctrl", ctrl_now(), 0);
    chk("post_init_waddr", waddr, 64);
    g_fin = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", ctrl_now(), 0);
    chk("reset_raddr", raddr, 0);
    chk("reset_waddr", waddr, 64);
    chk("reset_pre_sel", pre_sel, 0);
    @(negedge clk);
    init = 1'b0;

    run(10, 1'b0, -1, 0);          // nominal
    run(3, 1'b0, -1, 0);           // clamp low
    run(20, 1'b0, -1, 0);          // clamp high
    run(10, 1'b1, -1, 2);          // go held: single restart only after done
    pulse_init();
    run(10, 1'b0, 30, 0);          // reset mid-message
    run(10, 1'b0, -1, 20);         // fresh run, then 20 idle FIN cycles
    run(8, 1'b0, -1, 0);           // restart from FIN
    for (int k = 0; k < 4; k++) run(int'($urandom_range(0, 255)), 1'b0, -1, 0);
    run(7, 1'b0, -1, 0);
    run(12, 1'b0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_crypt_seq.md
Name: lfsr_crypt_seq

Overview:
- FSM sequencer that replaces the program-counter case decode driving the Lab 4 encryption datapath: dat_mem, the lfsr6 core, and the taps/start/pre_len temp registers.
- On a go pulse it:
  - loads the configuration bytes from dat_mem[61:63],
  - seeds the LFSR,
  - runs the preamble phase, then the message phase,
  - raises done.
- It sits in top_level between the testbench handshake and the datapath. It issues addresses, enables and the data_in mux select; it computes no data itself.

Parameters:
- MSG_LEN, 50: message bytes read from dat_mem[0..MSG_LEN-1].
- CFG_BASE, 61: address of pre_len. Taps are at CFG_BASE+1, start at CFG_BASE+2.
- DST_BASE, 64: first write address of the encrypted stream.
- PRE_MIN, 7: lower clamp on pre_len.
- PRE_MAX, 12: upper clamp on pre_len.

Ports:
- clk  in  1  system clock, rising edge.
- init  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE or FIN.
- data_out  in  8  dat_mem read data; asynchronous read, valid in the same cycle as raddr.
- raddr  out  8  dat_mem read address.
- waddr  out  8  dat_mem write address.
- write_en  out  1  dat_mem write enable.
- lfsr_en  out  1  advance LFSR one step at the clock edge.
- prelen_en  out  1  load pre_len temp register from data_out.
- taps_en  out  1  load taps temp register.
- start_en  out  1  load start temp register.
- load_lfsr  out  1  copy taps/start into lfsr6.
- pre_sel  out  1  data_in mux select:
  - 1: data_in = {2'b00,LFSR} ^ 8'h5F
  - 0: data_in = {2'b01, LFSR ^ data_out[5:0]}
- busy  out  1  high from CFG_PRE through MSG inclusive.
- done  out  1  high in FIN.

Behaviour:

States, in order: IDLE, CFG_PRE, CFG_TAPS, CFG_START, LOAD, PRE, MSG, FIN.

Reset:
- init=1 at a clock edge forces state=IDLE and clears pre_cnt, idx and the P register.
- During any cycle with init=1, write_en, lfsr_en and all load enables are forced to 0, regardless of state. This holds for reset mid-operation.
- Reset/idle output values: raddr=0, waddr=DST_BASE, pre_sel=0, busy=0, done=0.

State behaviour:
- IDLE: all enables 0. go=1 -> CFG_PRE.
- CFG_PRE (1 cycle):
  - raddr=CFG_BASE, prelen_en=1.
  - Internal P <= clamp(data_out, PRE_MIN, PRE_MAX), unsigned compare.
- CFG_TAPS (1 cycle): raddr=CFG_BASE+1, taps_en=1.
- CFG_START (1 cycle): raddr=CFG_BASE+2, start_en=1.
- LOAD (1 cycle): load_lfsr=1, lfsr_en=0. Clears idx.
- PRE (P cycles, idx=0..P-1):
  - write_en=1, lfsr_en=1, pre_sel=1, waddr=DST_BASE+idx.
  - When idx==P-1: idx<=0 and next state is MSG.
- MSG (MSG_LEN cycles, j=0..MSG_LEN-1):
  - write_en=1, lfsr_en=1, pre_sel=0, raddr=j, waddr=DST_BASE+P+j.
  - When j==MSG_LEN-1 -> FIN.
- FIN:
  - done=1, all enables 0.
  - done is held until init, or until go=1, which restarts at CFG_PRE (done drops on that edge).

Timing:
- go accepted at edge E0. The first preamble write is in cycle 5, counting the IDLE cycle with go as cycle 0.
- The last write is in cycle 4+P+MSG_LEN. done is first high in cycle 5+P+MSG_LEN.
- Total writes: exactly P+MSG_LEN.

Boundary conditions:
- go is ignored while busy=1.
- Unclamped pre_len values are never used for addressing.
- Address arithmetic is 8-bit. The maximum address is DST_BASE+PRE_MAX+MSG_LEN-1 = 125, so no wrap occurs at the defaults.
- The temp registers live outside this block.
- P and the counters are registered. raddr/waddr/enables are combinational from state and counters.

Test Plan:
1. pre_len=10, MSG_LEN=50, go pulse at cycle 0:
   - 60 writes to addresses 64..123: 10 with pre_sel=1, then 50 with pre_sel=0 and raddr 0..49.
   - done first high in cycle 65; busy high in cycles 1..64.
2. pre_len=3: P clamps to 7; writes go to 64..120; done in cycle 62. pre_len=20: P clamps to 12; last write address 125.
3. go held high for the entire run: no restart while busy. Exactly 60 writes, then done high for 1 cycle, then CFG_PRE again on the next edge.
4. init asserted in cycle 30 (mid-MSG):
   - write_en=0 in that cycle; state returns to IDLE; done stays 0.
   - A later go produces a complete fresh run with the first write again at address 64.
5. Enable ordering:
   - prelen_en, taps_en, start_en, load_lfsr each high for exactly one cycle, in cycles 1, 2, 3, 4, with raddr 61, 62, 63.
   - lfsr_en=0 through cycle 4.
6. FIN held 20 cycles with go=0: done stays 1 and there are no writes. A go pulse then restarts and done drops on the next edge.
